// File: rtl/edf_prio_pkg.sv
// Shared definitions for the EDF priority queue: default sizing, key type
// and the per-cycle operation applied to every sorted slot.
package edf_prio_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 32;
  localparam int unsigned CNT_W     = $clog2(DEF_DEPTH + 1);

  typedef logic [DEF_WIDTH-1:0] key_t;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

endpackage

// File: rtl/edf_prio_cell.sv
// One slot of the sorted array: holds a key plus occupied bit and picks its
// next value from itself, its neighbours or the incoming key.
module edf_prio_cell
  import edf_prio_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter bit          IS_HEAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [WIDTH-1:0] key_below_i,
  input  logic             occ_below_i,
  input  logic             le_below_i,
  input  logic [WIDTH-1:0] key_above_i,
  input  logic             occ_above_i,
  input  logic             le_above_i,
  output logic [WIDTH-1:0] key_o,
  output logic             occ_o,
  output logic             le_o
);

  logic [WIDTH-1:0] key_q, key_d;
  logic             occ_q, occ_d;
  logic             le;

  // Occupied entries with key <= din stay ahead of the new key (FIFO on ties).
  assign le = occ_q && (key_q <= din_i);

  always_comb begin
    key_d = key_q;
    occ_d = occ_q;
    case (op_i)
      OP_PUSH: begin
        if (!le) begin
          if (IS_HEAD || le_below_i) begin
            key_d = din_i;
            occ_d = 1'b1;
          end else begin
            key_d = key_below_i;
            occ_d = occ_below_i;
          end
        end
      end
      OP_POP: begin
        key_d = key_above_i;
        occ_d = occ_above_i;
      end
      // Pop-then-insert: the array seen by the insert is shifted down by one,
      // so the neighbour-above compare decides whether this slot takes it.
      OP_SWAP: begin
        if (le_above_i) begin
          key_d = key_above_i;
          occ_d = occ_above_i;
        end else if (IS_HEAD || le) begin
          key_d = din_i;
          occ_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
      occ_q <= 1'b0;
    end else begin
      key_q <= key_d;
      occ_q <= occ_d;
    end
  end

  assign key_o = key_q;
  assign occ_o = occ_q;
  assign le_o  = le;

endmodule

// File: rtl/edf_prio_fifo.sv
// Sorted priority queue: smallest key always at the head, ties leave in
// arrival order. One insert and/or one pop per cycle.
module edf_prio_fifo
  import edf_prio_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, empty, push, pop;
  op_e              op;

  // Slot i lives at index i+1; indices 0 and DEPTH+1 are empty padding.
  logic [WIDTH-1:0] key_x [DEPTH+2];
  logic [DEPTH+1:0] occ_x;
  logic [DEPTH+1:0] le_x;

  assign key_x[0]       = '0;
  assign key_x[DEPTH+1] = '0;
  assign occ_x[0]       = 1'b0;
  assign occ_x[DEPTH+1] = 1'b0;
  assign le_x[0]        = 1'b0;
  assign le_x[DEPTH+1]  = 1'b0;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = re && !empty;
  assign push  = we && (!full || pop);

  always_comb begin
    op    = OP_HOLD;
    cnt_d = cnt_q;
    case ({pop, push})
      2'b01: begin op = OP_PUSH; cnt_d = cnt_q + CW'(1); end
      2'b10: begin op = OP_POP;  cnt_d = cnt_q - CW'(1); end
      2'b11: op = OP_SWAP;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    edf_prio_cell #(
      .WIDTH   (WIDTH),
      .IS_HEAD (g == 0)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .op_i        (op),
      .din_i       (din),
      .key_below_i (key_x[g]),
      .occ_below_i (occ_x[g]),
      .le_below_i  (le_x[g]),
      .key_above_i (key_x[g+2]),
      .occ_above_i (occ_x[g+2]),
      .le_above_i  (le_x[g+2]),
      .key_o       (key_x[g+1]),
      .occ_o       (occ_x[g+1]),
      .le_o        (le_x[g+1])
    );
  end

  assign dout  = occ_x[1] ? key_x[1] : '0;
  assign valid = !empty;

endmodule

// File: tb/tb_edf_prio_fifo.sv
// Directed + randomized bench for edf_prio_fifo against a sorted-queue model.
module tb_edf_prio_fifo;

  localparam int unsigned W = 16;
  localparam int unsigned D = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         we  = 1'b0;
  logic         re  = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;
  logic         valid;

  int checks = 0;
  int errors = 0;
  int q[$];

  edf_prio_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .din   (din),
    .re    (re),
    .dout  (dout),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: pop the head, then insert after every key <= d.
  task automatic model(input bit w, input bit r, input int d);
    int k;
    if (r && q.size() > 0) void'(q.pop_front());
    if (w && q.size() < D) begin
      k = 0;
      while (k < q.size() && q[k] <= d) k++;
      q.insert(k, d);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_dout"},  dout, (q.size() > 0) ? W'(q[0]) : '0);
    chk({tag, "_valid"}, W'(valid), W'(q.size() > 0));
  endtask

  task automatic step(input string tag, input bit w, input bit r, input int d);
    we  = w;
    re  = r;
    din = W'(d);
    @(posedge clk);
    #1;
    model(w, r, d);
    we = 1'b0;
    re = 1'b0;
    check_model(tag);
  endtask

  int dir_keys[5] = '{150, 50, 120, 4, 200};
  int dir_out[5]  = '{4, 50, 120, 150, 200};

  initial begin
    repeat (20) @(posedge clk);
    #1;
    chk("reset_dout", dout, '0);
    chk("reset_valid", W'(valid), '0);
    rst = 1'b0;
    step("idle", 0, 0, 0);
    step("read_empty", 0, 1, 0);

    step("wr100", 1, 0, 100);
    chk("wr100_lit", dout, W'(100));
    step("rd100", 0, 1, 0);
    chk("rd100_valid", W'(valid), '0);

    foreach (dir_keys[i]) begin
      step("dir_wr", 1, 0, dir_keys[i]);
      step("dir_idle", 0, 0, 0);
    end
    chk("dir_head", dout, W'(4));
    foreach (dir_out[i]) begin
      chk("dir_order", dout, W'(dir_out[i]));
      step("dir_rd", 0, 1, 0);
    end
    chk("dir_empty", W'(valid), '0);

    for (int n = 0; n < 20; n++) begin
      step("rnd_wr", 1, 0, int'($urandom_range(200, 4)));
      repeat (10) step("rnd_idle", 0, 0, 0);
    end
    for (int n = 0; n < 20; n++) step("rnd_rd", 0, 1, 0);
    chk("rnd_empty", W'(valid), '0);

    for (int n = 0; n < int'(D); n++) step("fill", 1, 0, 10 + n);
    step("full_drop", 1, 0, 5);
    chk("full_drop_lit", dout, W'(10));
    step("full_swap", 1, 1, 5);
    chk("full_swap_lit", dout, W'(5));
    for (int n = 0; n < int'(D); n++) step("full_drain", 0, 1, 0);
    chk("full_drain_empty", W'(valid), '0);

    // Ties must leave in arrival order, interleaved with swaps on a partial queue.
    for (int n = 0; n < 40; n++)
      step("mix", $urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0,
           int'($urandom_range(12, 8)));

    while (q.size() > 0) step("mix_drain", 0, 1, 0);

    step("q30", 1, 0, 30);
    step("q60", 1, 0, 60);
    step("swap40", 1, 1, 40);
    chk("swap40_lit", dout, W'(40));
    step("rd40", 0, 1, 0);
    chk("rd40_lit", dout, W'(60));
    step("q25", 1, 0, 25);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    chk("async_rst_dout", dout, '0);
    chk("async_rst_valid", W'(valid), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst", 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
